// File: rtl/led_blink_pkg.sv
// Shared types for the multi-channel LED blinker: channel modes and the
// LED level a channel takes on the edge that writes its configuration.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // Only ON starts lit; blink and burst always begin from dark.
  function automatic logic led_init(input mode_e m);
    return (m == MODE_ON);
  endfunction

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: mode/half/burst registers, half-period counter, toggle,
// and the burst countdown that drops the channel to OFF when it finishes.
module led_blink_ch
  import led_blink_pkg::*;
#(
  parameter int          HALF_W   = 32,
  parameter int          BURST_W  = 8,
  parameter int unsigned DEF_HALF = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_we,
  input  mode_e              cfg_mode,
  input  logic [HALF_W-1:0]  cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               led,
  output logic               busy,
  output logic               burst_done
);

  mode_e              mode_q, mode_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [HALF_W-1:0]  count_q, count_d;
  logic [BURST_W-1:0] pulses_q, pulses_d;
  logic               led_q, led_d;
  logic               done_q, done_d;

  logic [HALF_W-1:0]  last_cnt;
  logic               term;

  // half==0 is treated as half==1, i.e. terminal count is 0.
  assign last_cnt = (half_q == '0) ? '0 : half_q - 1'b1;
  assign term     = (count_q == last_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= MODE_BLINK;
      half_q   <= HALF_W'(DEF_HALF);
      count_q  <= '0;
      pulses_q <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      half_q   <= half_d;
      count_q  <= count_d;
      pulses_q <= pulses_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    half_d   = half_q;
    count_d  = count_q;
    pulses_d = pulses_q;
    led_d    = led_q;
    done_d   = 1'b0;
    // A write takes priority over any terminal count landing on the same edge.
    if (cfg_we) begin
      mode_d   = cfg_mode;
      half_d   = cfg_half;
      pulses_d = cfg_burst;
      count_d  = '0;
      led_d    = led_init(cfg_mode);
    end else if (en) begin
      unique case (mode_q)
        MODE_OFF, MODE_ON: count_d = '0;
        MODE_BLINK: begin
          if (term) begin
            count_d = '0;
            led_d   = ~led_q;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        MODE_BURST: begin
          if (pulses_q == '0) begin
            // Zero-length burst: finish immediately without lighting.
            mode_d  = MODE_OFF;
            count_d = '0;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end else if (term) begin
            count_d = '0;
            led_d   = ~led_q;
            if (led_q) begin
              pulses_d = pulses_q - 1'b1;
              if (pulses_q == BURST_W'(1)) begin
                mode_d = MODE_OFF;
                done_d = 1'b1;
              end
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign led        = led_q;
  assign burst_done = done_q;
  assign busy       = (mode_q == MODE_BLINK) || (mode_q == MODE_BURST);

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker top: decodes the config write port into
// per-channel strobes and instantiates one led_blink_ch per output.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          HALF_W   = 32,
  parameter int unsigned DEF_HALF = 100000000,
  parameter int          BURST_W  = 8,
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [HALF_W-1:0]  cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  burst_done
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no strobe and are dropped.
    assign ch_we[i] = cfg_we && (32'(cfg_ch) == 32'(i));

    led_blink_ch #(
      .HALF_W  (HALF_W),
      .BURST_W (BURST_W),
      .DEF_HALF(DEF_HALF)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cfg_we    (ch_we[i]),
      .cfg_mode  (mode_e'(cfg_mode)),
      .cfg_half  (cfg_half),
      .cfg_burst (cfg_burst),
      .led       (led[i]),
      .busy      (busy[i]),
      .burst_done(burst_done[i])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench: a 4-channel and a 3-channel instance share all inputs so
// that a write to channel 3 is live on one and out of range on the other.
module tb_led_blink_multi;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_we;
  logic [1:0]  cfg_ch, cfg_mode;
  logic [31:0] cfg_half;
  logic [7:0]  cfg_burst;
  logic [3:0]  led, busy, done;
  logic [2:0]  led3, busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_blink_multi #(.NUM_CH(4), .HALF_W(32), .DEF_HALF(4), .BURST_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
    .led(led), .busy(busy), .burst_done(done)
  );

  led_blink_multi #(.NUM_CH(3), .HALF_W(32), .DEF_HALF(4), .BURST_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
    .led(led3), .busy(busy3), .burst_done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] m,
                    input logic [31:0] h, input logic [7:0] b);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_half = h; cfg_burst = b;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_burst = '0;
    tick(); tick();
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led got %h exp 0", led); end
    checks++; if (busy !== 4'hF) begin errors++; $display("FAIL reset_busy got %h exp f", busy); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done got %h exp 0", done); end
    checks++; if (busy3 !== 3'h7) begin errors++; $display("FAIL reset_busy3 got %h exp 7", busy3); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL blink_pre got %h exp 0", led); end
    tick();
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL blink_first got %h exp f", led); end
    tick(); tick(); tick(); tick();
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL blink_second got %h exp 0", led); end
  endtask

  task automatic test_on_off();
    tick(); tick(); tick(); tick();
    wr(2'd1, 2'd1, 32'd4, 8'd0);
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL on_write got %b exp 1", led[1]); end
    wr(2'd2, 2'd0, 32'd4, 8'd0);
    checks++; if (led !== 4'b1011) begin errors++; $display("FAIL off_write got %b exp 1011", led); end
    checks++; if (led3 !== 3'b011) begin errors++; $display("FAIL off_write3 got %b exp 011", led3); end
    tick(); tick();
    checks++; if (led !== 4'b0010) begin errors++; $display("FAIL static_a got %b exp 0010", led); end
    checks++; if (busy !== 4'b1001) begin errors++; $display("FAIL static_busy got %b exp 1001", busy); end
    tick(); tick(); tick(); tick();
    checks++; if (led !== 4'b1011) begin errors++; $display("FAIL static_b got %b exp 1011", led); end
  endtask

  task automatic test_burst();
    logic [12:0] exp_led, exp_done;
    int rises;
    logic prev;
    exp_led  = 13'b0011001100110;
    exp_done = 13'b0100000000000;
    wr(2'd0, 2'd3, 32'd2, 8'd3);
    checks++; if (led[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL burst_start got led=%b busy=%b exp 0 1", led[0], busy[0]); end
    rises = 0; prev = led[0];
    for (int i = 0; i < 13; i++) begin
      tick();
      if (led[0] && !prev) rises++;
      prev = led[0];
      checks++; if (led[0] !== exp_led[i] || done[0] !== exp_done[i]) begin
        errors++; $display("FAIL burst_seq[%0d] got led=%b done=%b exp %b %b",
                           i, led[0], done[0], exp_led[i], exp_done[i]); end
    end
    checks++; if (rises != 3) begin errors++; $display("FAIL burst_pulses got %0d exp 3", rises); end
    checks++; if (busy[0] !== 1'b0 || busy3[0] !== 1'b0) begin
      errors++; $display("FAIL burst_busy got %b/%b exp 0/0", busy[0], busy3[0]); end
  endtask

  task automatic test_half0_invalid();
    logic [3:0] exp3;
    exp3 = 4'b0101;
    wr(2'd3, 2'd2, 32'd0, 8'd0);
    checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL half0_write got %b exp 0", led[3]); end
    checks++; if (led3 !== 3'b010 || busy3 !== 3'b000) begin
      errors++; $display("FAIL invalid_ch got led=%b busy=%b exp 010 000", led3, busy3); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (led[3] !== exp3[i]) begin
        errors++; $display("FAIL half0_toggle[%0d] got %b exp %b", i, led[3], exp3[i]); end
    end
    checks++; if (led3 !== 3'b010) begin errors++; $display("FAIL invalid_hold got %b exp 010", led3); end
  endtask

  task automatic test_en_freeze();
    logic [3:0] snap;
    wr(2'd2, 2'd2, 32'd5, 8'd0);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL freeze_write got %b exp 0", led[2]); end
    tick(); tick();
    en = 1'b0;
    snap = led;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) wr(2'd1, 2'd0, 32'd1, 8'd0);
      else tick();
      checks++; if (led[3:2] !== snap[3:2] || done !== 4'h0) begin
        errors++; $display("FAIL freeze[%0d] got led=%b done=%b exp %b 0000",
                           i, led, done, snap); end
    end
    checks++; if (led[1] !== 1'b0) begin errors++; $display("FAIL freeze_wr got %b exp 0", led[1]); end
    en = 1'b1;
    tick(); tick();
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL resume_early got %b exp 0", led[2]); end
    tick();
    checks++; if (led[2] !== 1'b1) begin errors++; $display("FAIL resume_toggle got %b exp 1", led[2]); end
  endtask

  task automatic test_burst_reset();
    wr(2'd0, 2'd3, 32'd2, 8'd2);
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL brst_start got %b exp 0", led[0]); end
    tick(); tick(); tick();
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL brst_high got %b exp 1", led[0]); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (led !== 4'h0 || done !== 4'h0 || busy !== 4'hF) begin
      errors++; $display("FAIL brst_reset got led=%h done=%h busy=%h exp 0 0 f", led, done, busy); end
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++; if (done !== 4'h0) begin errors++; $display("FAIL brst_nodone[%0d] got %h exp 0", i, done); end
      if (i == 3) begin
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL brst_def_pre got %h exp 0", led); end
      end
      if (i == 4) begin
        checks++; if (led !== 4'hF) begin errors++; $display("FAIL brst_def_tog got %h exp f", led); end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Write lands on the same edge as ch2's terminal count: forced 0, no toggle.
    wr(2'd2, 2'd2, 32'd4, 8'd0);
    checks++; if (led !== 4'b1011) begin errors++; $display("FAIL collide got %b exp 1011", led); end
    checks++; if (led3 !== 3'b011) begin errors++; $display("FAIL collide3 got %b exp 011", led3); end
    wr(2'd1, 2'd3, 32'd3, 8'd0);
    checks++; if (led !== 4'b1001 || busy !== 4'hF || done !== 4'h0) begin
      errors++; $display("FAIL b0_write got led=%b busy=%b done=%b exp 1001 1111 0000", led, busy, done); end
    tick();
    checks++; if (done !== 4'b0010 || busy !== 4'b1101 || led[1] !== 1'b0) begin
      errors++; $display("FAIL b0_done got done=%b busy=%b led1=%b exp 0010 1101 0", done, busy, led[1]); end
    checks++; if (done3 !== 3'b010) begin errors++; $display("FAIL b0_done3 got %b exp 010", done3); end
    tick();
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL b0_pulse got %b exp 0000", done); end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_burst();
    test_half0_invalid();
    test_en_freeze();
    test_burst_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
